memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Pipeline stage downstream of execute. Consumes the execute-stage register outputs and performs loads and stores against data memory through a req/ack handshake.
- Produces store byte enables, and sign- or zero-extends load data.
- Registers the results toward writeback.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- ACK_TIMEOUT, 255, max cycles to wait for i_dmem_ack before aborting with an error (range 1..65535).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- i_valid  in  1  execute-stage outputs hold a live instruction.
- i_inst  in  32  instruction; bits [6:0] are the opcode.
- i_alu_result  in  32  effective address for memory ops, else the result.
- i_store_data  in  32  rs2 value for stores.
- i_mem_rw  in  1  1 = store, 0 = load; only meaningful for memory opcodes.
- i_load_store_mode  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_wb_sel  in  2  writeback select, passed through.
- i_pc_sel  in  1  passed through.
- i_pc  in  32  passed through.
- i_pc_inc  in  32  passed through.
- o_stall  out  1  upstream must hold its registers.
- o_dmem_req  out  1  request valid.
- o_dmem_we  out  1  write enable.
- o_dmem_addr  out  32  word address, bits [1:0] = 0.
- o_dmem_wdata  out  32  lane-aligned store data.
- o_dmem_be  out  4  byte enables.
- i_dmem_ack  in  1  request completed.
- i_dmem_rdata  in  32  read word, valid when ack = 1.
- o_mem_valid  out  1  writeback registers hold a live instruction.
- o_mem_inst, o_mem_alu_result, o_mem_pc, o_mem_pc_inc  out  32 each  registered pass-through.
- o_mem_wb_sel  out  2  registered pass-through.
- o_mem_pc_sel  out  1  registered pass-through.
- o_mem_load_data  out  32  extended load result; 0 for non-loads.
- o_mem_fault  out  1  misaligned access or ack timeout.

Behaviour:
- Memory op: opcode 0000011 (load) or 0100011 (store).
- Misaligned conditions:
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
  - Modes 011, 110, 111 are treated as faults.
- FSM states: IDLE and WAIT.
- IDLE, i_valid = 0: o_mem_valid <= 0.
- IDLE, non-memory op: pass-through in 1 cycle. o_mem_load_data <= 0, o_mem_fault <= 0, no stall.
- IDLE, memory op, misaligned: no request issued. 1-cycle pass-through with o_mem_fault <= 1 and load data 0.
- IDLE, memory op, aligned:
  - o_stall = 1 combinationally in that cycle.
  - Latch op, address, wdata, be and all pass-through fields; go to WAIT.
  - Clear the timeout counter; o_mem_valid <= 0.
- Store lanes:
  - B: be = 1 << addr[1:0]; wdata = byte replicated ×4.
  - H: be = 0011 << addr[1:0]; wdata = halfword replicated ×2.
  - W: be = 1111.
- Loads: o_dmem_we = 0, be = 1111.
- WAIT:
  - o_dmem_req = 1 (registered) and o_stall = 1; address, data and be are held stable.
  - Ack may arrive in the first WAIT cycle.
  - On ack: o_mem_valid <= 1, load data extended from the lane selected by addr[1:0] (B/H sign-extend; BU/HU zero-extend; stores give 0), then go to IDLE.
  - o_stall drops in the ack cycle so upstream advances on the same edge.
  - Without ack: counter increments. When the counter reaches ACK_TIMEOUT-1 with no ack, go to IDLE with o_mem_valid <= 1, o_mem_fault <= 1, load data 0.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no fault.
- Throughput: one memory op per (latency + 1) cycles; back-to-back memory ops re-enter WAIT after the single IDLE cycle.
- Reset (reset = 0, any time including mid-transaction):
  - State goes to IDLE and the counter to 0 immediately.
  - o_dmem_req, we and be = 0; addr and wdata = 0; o_stall = 0.
  - All o_mem_* outputs = 0.
  - An in-flight ack after reset is ignored.

Test Plan:
1. Non-memory op: i_inst = 0x00A28293 (addi), alu_result = 0x1234, i_valid = 1 → next cycle o_mem_valid = 1, o_mem_alu_result = 0x1234, load_data = 0, no dmem_req, o_stall never 1.
2. SB: addr = 0x1003, store_data = 0x000000AB, ack after 3 cycles → dmem_addr = 0x1000, be = 1000, wdata = 0xABABABAB; o_stall high 4 cycles; o_mem_valid pulse 1 cycle after ack.
3. LB/LBU: addr = 0x2002, rdata = 0x00800000, ack in first WAIT cycle → LB gives 0xFFFFFF80, LBU gives 0x00000080.
4. LH: addr = 0x3001 → no dmem_req, o_mem_fault = 1 next cycle, load_data = 0. LW: addr = 0x3004, rdata = 0xDEADBEEF → 0xDEADBEEF.
5. Timeout with ACK_TIMEOUT = 4, no ack → req high exactly 4 cycles, then o_mem_fault = 1 and o_mem_valid = 1. Repeat with ack on the 4th cycle → fault = 0.
6. Drive reset = 0 in the 2nd WAIT cycle, then ack = 1 → req/stall/o_mem_* are 0 without a clock edge; after release, the next op behaves per scenario 1.

Source files
------------

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory stage: data-memory load/store over req/ack with lane steering,
// load extension, misalignment and ack-timeout faults, registered toward writeback.
module memory_access #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    input  logic        i_mem_rw,
    input  logic [2:0]  i_load_store_mode,
    input  logic [1:0]  i_wb_sel,
    input  logic        i_pc_sel,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_inc,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_mem_valid,
    output logic [31:0] o_mem_inst,
    output logic [31:0] o_mem_alu_result,
    output logic [31:0] o_mem_pc,
    output logic [31:0] o_mem_pc_inc,
    output logic [1:0]  o_mem_wb_sel,
    output logic        o_mem_pc_sel,
    output logic [31:0] o_mem_load_data,
    output logic        o_mem_fault
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

    logic [0:0]  state;
    logic [15:0] cnt;

    logic [31:0] l_inst, l_alu, l_pc, l_pc_inc;
    logic [1:0]  l_wb_sel;
    logic        l_pc_sel;
    logic [2:0]  l_mode;

    logic        is_mem, misaligned, mem_go, timeout;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign is_mem  = (i_inst[6:0] == 7'b0000011) || (i_inst[6:0] == 7'b0100011);
    assign mem_go  = (state == S_IDLE) && i_valid && is_mem && !misaligned;
    assign timeout = (cnt == TIMEOUT_LAST);

    // Stall is gated by reset so upstream is released the moment reset asserts.
    assign o_stall    = reset && (mem_go || ((state == S_WAIT) && !i_dmem_ack));
    assign o_dmem_req = (state == S_WAIT);

    always_comb begin
        misaligned = 1'b1;
        case (i_load_store_mode)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = i_alu_result[0];
            3'b010:         misaligned = (i_alu_result[1:0] != 2'b00);
            default:        misaligned = 1'b1;
        endcase
    end

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = 32'h0;
        if (i_mem_rw) begin
            case (i_load_store_mode[1:0])
                2'b00: begin
                    be_n    = 4'b0001 << i_alu_result[1:0];
                    wdata_n = {4{i_store_data[7:0]}};
                end
                2'b01: begin
                    be_n    = 4'b0011 << i_alu_result[1:0];
                    wdata_n = {2{i_store_data[15:0]}};
                end
                default: begin
                    be_n    = 4'b1111;
                    wdata_n = i_store_data;
                end
            endcase
        end
    end

    // Lane select uses the latched address; rdata is only meaningful in the ack cycle.
    always_comb begin
        ld_byte = 8'h0;
        case (l_alu[1:0])
            2'b00: ld_byte = i_dmem_rdata[7:0];
            2'b01: ld_byte = i_dmem_rdata[15:8];
            2'b10: ld_byte = i_dmem_rdata[23:16];
            default: ld_byte = i_dmem_rdata[31:24];
        endcase
        ld_half = l_alu[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        ld_ext  = 32'h0;
        if (!o_dmem_we) begin
            case (l_mode)
                3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
                3'b100:  ld_ext = {24'h0, ld_byte};
                3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
                3'b101:  ld_ext = {16'h0, ld_half};
                3'b010:  ld_ext = i_dmem_rdata;
                default: ld_ext = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            cnt              <= 16'h0;
            o_dmem_we        <= 1'b0;
            o_dmem_be        <= 4'h0;
            o_dmem_addr      <= 32'h0;
            o_dmem_wdata     <= 32'h0;
            l_inst           <= 32'h0;
            l_alu            <= 32'h0;
            l_pc             <= 32'h0;
            l_pc_inc         <= 32'h0;
            l_wb_sel         <= 2'b00;
            l_pc_sel         <= 1'b0;
            l_mode           <= 3'b000;
            o_mem_valid      <= 1'b0;
            o_mem_inst       <= 32'h0;
            o_mem_alu_result <= 32'h0;
            o_mem_pc         <= 32'h0;
            o_mem_pc_inc     <= 32'h0;
            o_mem_wb_sel     <= 2'b00;
            o_mem_pc_sel     <= 1'b0;
            o_mem_load_data  <= 32'h0;
            o_mem_fault      <= 1'b0;
        end else if (state == S_IDLE) begin
            if (!i_valid) begin
                o_mem_valid <= 1'b0;
            end else if (mem_go) begin
                state        <= S_WAIT;
                cnt          <= 16'h0;
                o_mem_valid  <= 1'b0;
                o_dmem_we    <= i_mem_rw;
                o_dmem_be    <= be_n;
                o_dmem_addr  <= {i_alu_result[31:2], 2'b00};
                o_dmem_wdata <= wdata_n;
                l_inst       <= i_inst;
                l_alu        <= i_alu_result;
                l_pc         <= i_pc;
                l_pc_inc     <= i_pc_inc;
                l_wb_sel     <= i_wb_sel;
                l_pc_sel     <= i_pc_sel;
                l_mode       <= i_load_store_mode;
            end else begin
                o_mem_valid      <= 1'b1;
                o_mem_inst       <= i_inst;
                o_mem_alu_result <= i_alu_result;
                o_mem_pc         <= i_pc;
                o_mem_pc_inc     <= i_pc_inc;
                o_mem_wb_sel     <= i_wb_sel;
                o_mem_pc_sel     <= i_pc_sel;
                o_mem_load_data  <= 32'h0;
                o_mem_fault      <= is_mem && misaligned;
            end
        end else begin
            if (i_dmem_ack || timeout) begin
                state            <= S_IDLE;
                o_mem_valid      <= 1'b1;
                o_mem_inst       <= l_inst;
                o_mem_alu_result <= l_alu;
                o_mem_pc         <= l_pc;
                o_mem_pc_inc     <= l_pc_inc;
                o_mem_wb_sel     <= l_wb_sel;
                o_mem_pc_sel     <= l_pc_sel;
                o_mem_load_data  <= i_dmem_ack ? ld_ext : 32'h0;
                o_mem_fault      <= !i_dmem_ack;
                o_dmem_we        <= 1'b0;
                o_dmem_be        <= 4'h0;
                o_dmem_addr      <= 32'h0;
                o_dmem_wdata     <= 32'h0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - randomized and directed bench for memory_access against a behavioural model.
module tb_memory_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_inst, i_alu_result, i_store_data, i_pc, i_pc_inc;
    logic        i_mem_rw, i_pc_sel;
    logic [2:0]  i_load_store_mode;
    logic [1:0]  i_wb_sel;
    logic        o_stall, o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_mem_valid;
    logic [31:0] o_mem_inst, o_mem_alu_result, o_mem_pc, o_mem_pc_inc, o_mem_load_data;
    logic [1:0]  o_mem_wb_sel;
    logic        o_mem_pc_sel, o_mem_fault;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_access #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_inst(i_inst),
        .i_alu_result(i_alu_result), .i_store_data(i_store_data), .i_mem_rw(i_mem_rw),
        .i_load_store_mode(i_load_store_mode), .i_wb_sel(i_wb_sel), .i_pc_sel(i_pc_sel),
        .i_pc(i_pc), .i_pc_inc(i_pc_inc), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
        .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_mem_valid(o_mem_valid), .o_mem_inst(o_mem_inst), .o_mem_alu_result(o_mem_alu_result),
        .o_mem_pc(o_mem_pc), .o_mem_pc_inc(o_mem_pc_inc), .o_mem_wb_sel(o_mem_wb_sel),
        .o_mem_pc_sel(o_mem_pc_sel), .o_mem_load_data(o_mem_load_data), .o_mem_fault(o_mem_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Access size in bytes; 0 marks an illegal mode.
    function automatic int acc_size(input logic [2:0] m);
        if (m == 3'b011 || m == 3'b110 || m == 3'b111) return 0;
        if (m[1:0] == 2'b00) return 1;
        if (m[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_bad(input logic [2:0] m, input logic [31:0] a);
        int s = acc_size(m);
        return (s == 0) || ((a % s) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] m, input logic [31:0] a, input logic we);
        int s = acc_size(m);
        if (!we) return 4'hF;
        return 4'(((1 << s) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] m, input logic [31:0] d);
        int s = acc_size(m);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = d[(i % s)*8 +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] m, input logic [31:0] a,
                                               input logic [31:0] rd, input logic we);
        int s = acc_size(m);
        longint mask;
        longint v;
        if (we) return 32'h0;
        v = longint'(rd) >> (8 * (a % 4));
        if (s == 4) return rd;
        mask = (longint'(1) << (8 * s)) - 1;
        v = v & mask;
        if (!m[2] && ((v >> (8 * s - 1)) & 1) == 1) v = v | ~mask;
        return 32'(v);
    endfunction

    task automatic run_op(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] sd,
                          input logic rw, input logic [2:0] mode, input int lat,
                          input bit give_ack, input logic [31:0] rd);
        logic [31:0] pc, pci;
        logic [1:0]  wbs;
        logic        pcs;
        bit mem, bad, go, ack_now, done, fault;
        mem = (inst[6:0] == 7'b0000011) || (inst[6:0] == 7'b0100011);
        bad = mem && is_bad(mode, alu);
        go  = mem && !bad;
        pc = $urandom; pci = $urandom; wbs = 2'($urandom); pcs = 1'($urandom);
        i_valid = 1'b1; i_inst = inst; i_alu_result = alu; i_store_data = sd;
        i_mem_rw = rw; i_load_store_mode = mode; i_pc = pc; i_pc_inc = pci;
        i_wb_sel = wbs; i_pc_sel = pcs;
        #1;
        check("stall_idle", 32'(o_stall), 32'(go));
        @(posedge clk); #1;
        if (go) begin
            done = 0;
            for (int k = 0; k < TO && !done; k++) begin
                ack_now = give_ack && (k == lat);
                i_dmem_ack = ack_now;
                i_dmem_rdata = ack_now ? rd : $urandom;
                #1;
                check("wait_req", 32'(o_dmem_req), 32'd1);
                check("wait_we", 32'(o_dmem_we), 32'(rw));
                check("wait_addr", o_dmem_addr, alu & 32'hFFFF_FFFC);
                check("wait_be", 32'(o_dmem_be), 32'(model_be(mode, alu, rw)));
                if (rw) check("wait_wdata", o_dmem_wdata, model_wdata(mode, sd));
                check("wait_valid", 32'(o_mem_valid), 32'd0);
                check("wait_stall", 32'(o_stall), 32'(!ack_now));
                @(posedge clk); #1;
                i_dmem_ack = 1'b0;
                if (ack_now || k == TO - 1) done = 1;
            end
        end
        fault = bad || (go && !(give_ack && lat < TO));
        check("out_valid", 32'(o_mem_valid), 32'd1);
        check("out_fault", 32'(o_mem_fault), 32'(fault));
        check("out_load", o_mem_load_data, (mem && !fault) ? model_load(mode, alu, rd, rw) : 32'h0);
        check("out_alu", o_mem_alu_result, alu);
        check("out_inst", o_mem_inst, inst);
        check("out_pc", o_mem_pc, pc);
        check("out_pc_inc", o_mem_pc_inc, pci);
        check("out_wb_sel", 32'(o_mem_wb_sel), 32'(wbs));
        check("out_pc_sel", 32'(o_mem_pc_sel), 32'(pcs));
        check("out_req", 32'(o_dmem_req), 32'd0);
    endtask

    localparam logic [31:0] ADDI = 32'h00A28293;
    localparam logic [31:0] LD   = 32'h00002003;
    localparam logic [31:0] ST   = 32'h00002023;

    initial begin
        reset = 1'b0; i_valid = 1'b0; i_inst = 0; i_alu_result = 0; i_store_data = 0;
        i_mem_rw = 0; i_load_store_mode = 0; i_wb_sel = 0; i_pc_sel = 0; i_pc = 0;
        i_pc_inc = 0; i_dmem_ack = 0; i_dmem_rdata = 0;
        #12;
        check("rst_req", 32'(o_dmem_req), 32'd0);
        check("rst_stall", 32'(o_stall), 32'd0);
        check("rst_be", 32'(o_dmem_be), 32'd0);
        check("rst_valid", 32'(o_mem_valid), 32'd0);
        check("rst_load", o_mem_load_data, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(ADDI, 32'h1234, 32'h0, 1'b0, 3'b000, 0, 1, 32'h0);
        run_op(ST, 32'h1003, 32'h000000AB, 1'b1, 3'b000, 3, 1, 32'h0);
        check("sb_wdata_const", model_wdata(3'b000, 32'hAB), 32'hABABABAB);
        run_op(LD, 32'h2002, 32'h0, 1'b0, 3'b000, 0, 1, 32'h00800000);
        check("lb_result", o_mem_load_data, 32'hFFFFFF80);
        run_op(LD, 32'h2002, 32'h0, 1'b0, 3'b100, 0, 1, 32'h00800000);
        check("lbu_result", o_mem_load_data, 32'h00000080);
        run_op(LD, 32'h3001, 32'h0, 1'b0, 3'b001, 0, 1, 32'h0);
        run_op(LD, 32'h3004, 32'h0, 1'b0, 3'b010, 1, 1, 32'hDEADBEEF);
        check("lw_result", o_mem_load_data, 32'hDEADBEEF);
        run_op(LD, 32'h5000, 32'h0, 1'b0, 3'b010, 0, 0, 32'h0);
        run_op(LD, 32'h5000, 32'h0, 1'b0, 3'b010, TO - 1, 1, 32'h12345678);
        run_op(ST, 32'h6002, 32'hCAFE1234, 1'b1, 3'b001, 2, 1, 32'h0);
        run_op(ST, 32'h6000, 32'hCAFE1234, 1'b1, 3'b011, 0, 1, 32'h0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] inst;
            int sel = $urandom_range(0, 4);
            inst = (sel < 2) ? LD : ((sel < 4) ? ST : ADDI);
            run_op(inst, $urandom, $urandom, (inst == ST), 3'($urandom),
                   $urandom_range(0, TO + 1), ($urandom_range(0, 9) != 0), $urandom);
        end

        // Reset in the second WAIT cycle, followed by a stray ack.
        i_valid = 1'b1; i_inst = LD; i_alu_result = 32'h4000; i_mem_rw = 1'b0;
        i_load_store_mode = 3'b010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_req", 32'(o_dmem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("arst_req", 32'(o_dmem_req), 32'd0);
        check("arst_stall", 32'(o_stall), 32'd0);
        check("arst_be", 32'(o_dmem_be), 32'd0);
        check("arst_addr", o_dmem_addr, 32'h0);
        check("arst_valid", 32'(o_mem_valid), 32'd0);
        check("arst_alu", o_mem_alu_result, 32'h0);
        check("arst_inst", o_mem_inst, 32'h0);
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        check("arst_ack_req", 32'(o_dmem_req), 32'd0);
        reset = 1'b1; i_dmem_ack = 1'b0; i_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_req", 32'(o_dmem_req), 32'd0);
        check("post_rst_valid", 32'(o_mem_valid), 32'd0);
        run_op(ADDI, 32'h1234, 32'h0, 1'b0, 3'b000, 0, 1, 32'h0);
        i_valid = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
